// File: rtl/lock_pkg.sv
// Shared types for the combination lock core: state encoding and LED decode masks.
// Each mask holds one bit per state code, so bit N lights the LED in state N.
package lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENTRY    = 3'd1,
      ST_UNLOCKED = 3'd2,
      ST_ERROR    = 3'd3,
      ST_LOCKOUT  = 3'd4,
      ST_PROGRAM  = 3'd5
   } state_t;

   localparam logic [7:0] LOCKED_MASK   = 8'b0001_1011;
   localparam logic [7:0] UNLOCKED_MASK = 8'b0010_0100;
   localparam logic [7:0] ERROR_MASK    = 8'b0000_1000;
   localparam logic [7:0] LOCKOUT_MASK  = 8'b0001_0000;

endpackage

// File: rtl/lock_btn_edge.sv
// Rising-edge detector for an already-synchronised button level.
// A single history flop means a held button yields exactly one event.
module lock_btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic evt
);

   logic btn_q;

   always_ff @(posedge clk) begin
      if (reset) btn_q <= 1'b0;
      else       btn_q <= btn;
   end

   assign evt = btn & ~btn_q;

endmodule

// File: rtl/lock_core_param.sv
// Parametrised digit-entry combination lock: code check, failure lockout,
// entry timeout and reprogramming, with one shared duration counter.
module lock_core_param
   import lock_pkg::*;
#(
   parameter int DIGIT_W        = 4,
   parameter int CODE_LEN       = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
   parameter int MAX_FAIL       = 3,
   parameter int ERR_CYCLES     = 8,
   parameter int LOCKOUT_CYCLES = 1024,
   parameter int ENTRY_TIMEOUT  = 4096
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DIGIT_W-1:0]              in_digit,
   input  logic                            enter_btn,
   input  logic                            relock_btn,
   input  logic                            prog_btn,
   output logic                            locked_led,
   output logic                            unlocked_led,
   output logic                            error_led,
   output logic                            lockout_led,
   output logic [2:0]                      state_leds,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

   localparam int CODE_W  = CODE_LEN * DIGIT_W;
   localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
   localparam int IDX_W   = $clog2(CODE_LEN + 1);
   localparam int CNT_MAX = (ERR_CYCLES > LOCKOUT_CYCLES)
                            ? ((ERR_CYCLES > ENTRY_TIMEOUT) ? ERR_CYCLES : ENTRY_TIMEOUT)
                            : ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]  ERR_LAST  = CNT_W'(ERR_CYCLES - 1);
   localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(ENTRY_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);

   logic enter_evt, relock_evt, prog_evt;

   lock_btn_edge u_enter_edge  (.clk(clk), .reset(reset), .btn(enter_btn),  .evt(enter_evt));
   lock_btn_edge u_relock_edge (.clk(clk), .reset(reset), .btn(relock_btn), .evt(relock_evt));
   lock_btn_edge u_prog_edge   (.clk(clk), .reset(reset), .btn(prog_btn),   .evt(prog_evt));

   state_t              state_q, state_n;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic [IDX_W-1:0]    idx_q, idx_n;
   logic                flag_q, flag_n;
   logic [FAIL_W-1:0]   fail_q, fail_n;
   logic [CODE_W-1:0]   shadow_q, shadow_n;
   logic [CODE_W-1:0]   code_q, code_n;

   logic [DIGIT_W-1:0]  cur_digit;
   logic                miss;
   logic [CODE_W-1:0]   shadow_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         flag_q   <= 1'b0;
         fail_q   <= '0;
         shadow_q <= '0;
         code_q   <= DEFAULT_CODE;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         idx_q    <= idx_n;
         flag_q   <= flag_n;
         fail_q   <= fail_n;
         shadow_q <= shadow_n;
         code_q   <= code_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      idx_n    = idx_q;
      flag_n   = flag_q;
      fail_n   = fail_q;
      shadow_n = shadow_q;
      code_n   = code_q;

      // Digit 0 is the most-significant digit of the code word.
      cur_digit = code_q[(CODE_LEN - 1 - int'(idx_q)) * DIGIT_W +: DIGIT_W];
      miss      = flag_q | (in_digit != cur_digit);
      shadow_wr = shadow_q;
      shadow_wr[(CODE_LEN - 1 - int'(idx_q)) * DIGIT_W +: DIGIT_W] = in_digit;

      unique case (state_q)
         // IDLE holds idx = 0, so it shares the digit path with ENTRY.
         ST_IDLE, ST_ENTRY: begin
            if (enter_evt) begin
               cnt_n = '0;
               if (idx_q == IDX_LAST) begin
                  idx_n  = '0;
                  flag_n = 1'b0;
                  if (!miss) begin
                     state_n = ST_UNLOCKED;
                     fail_n  = '0;
                  end else begin
                     state_n = ST_ERROR;
                     fail_n  = (fail_q == FAIL_MAX) ? fail_q : fail_q + FAIL_W'(1);
                  end
               end else begin
                  state_n = ST_ENTRY;
                  idx_n   = idx_q + IDX_W'(1);
                  flag_n  = miss;
               end
            end else if (state_q == ST_ENTRY) begin
               if (cnt_q == TO_LAST) begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
                  idx_n   = '0;
                  flag_n  = 1'b0;
               end else begin
                  cnt_n = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_ERROR: begin
            if (cnt_q == ERR_LAST) begin
               cnt_n   = '0;
               state_n = (fail_q == FAIL_MAX) ? ST_LOCKOUT : ST_IDLE;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end

         ST_LOCKOUT: begin
            if (cnt_q == LOCK_LAST) begin
               cnt_n   = '0;
               state_n = ST_IDLE;
               fail_n  = '0;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end

         ST_UNLOCKED: begin
            if (relock_evt) begin
               state_n = ST_IDLE;
            end else if (prog_evt) begin
               state_n  = ST_PROGRAM;
               cnt_n    = '0;
               idx_n    = '0;
               shadow_n = '0;
            end
         end

         ST_PROGRAM: begin
            if (relock_evt || (!enter_evt && cnt_q == TO_LAST)) begin
               state_n  = ST_IDLE;
               cnt_n    = '0;
               idx_n    = '0;
               shadow_n = '0;
            end else if (enter_evt) begin
               cnt_n = '0;
               if (idx_q == IDX_LAST) begin
                  code_n   = shadow_wr;
                  state_n  = ST_IDLE;
                  idx_n    = '0;
                  shadow_n = '0;
               end else begin
                  shadow_n = shadow_wr;
                  idx_n    = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end

         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      locked_led   = LOCKED_MASK[state_q];
      unlocked_led = UNLOCKED_MASK[state_q];
      error_led    = ERROR_MASK[state_q];
      lockout_led  = LOCKOUT_MASK[state_q];
      state_leds   = state_q;
      fail_count   = fail_q;
   end

endmodule

// File: tb/tb_lock_core_param.sv
// Randomised and directed bench for lock_core_param against a deadline/queue based model.
module tb_lock_core_param;

   localparam int DW = 4;
   localparam int CL = 4;
   localparam int MF = 3;
   localparam int EC = 8;
   localparam int LC = 32;
   localparam int ET = 64;
   localparam logic [15:0] DEF = 16'h1234;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in_digit = '0;
   logic       enter_btn = 1'b0;
   logic       relock_btn = 1'b0;
   logic       prog_btn = 1'b0;
   logic       locked_led, unlocked_led, error_led, lockout_led;
   logic [2:0] state_leds;
   logic [1:0] fail_count;

   always #5 clk = ~clk;

   lock_core_param #(
      .DIGIT_W(DW), .CODE_LEN(CL), .DEFAULT_CODE(DEF), .MAX_FAIL(MF),
      .ERR_CYCLES(EC), .LOCKOUT_CYCLES(LC), .ENTRY_TIMEOUT(ET)
   ) dut (
      .clk(clk), .reset(reset), .in_digit(in_digit), .enter_btn(enter_btn),
      .relock_btn(relock_btn), .prog_btn(prog_btn), .locked_led(locked_led),
      .unlocked_led(unlocked_led), .error_led(error_led), .lockout_led(lockout_led),
      .state_leds(state_leds), .fail_count(fail_count)
   );

   int n_pass = 0;
   int n_total = 0;
   int n_fail_lines = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else begin
         if (n_fail_lines < 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
         n_fail_lines++;
      end
   endtask

   // Behavioural model: mode number, absolute-cycle deadlines and digit queues.
   int m_state, m_fail, m_deadline, cyc;
   int m_code[CL];
   int m_entry[$];
   int m_shadow[$];
   bit pe, pr, pp, ee, er, ep;
   bit model_ok = 0;

   function automatic void model_reset();
      m_state = 0;
      m_fail  = 0;
      for (int i = 0; i < CL; i++) m_code[i] = int'((DEF >> (4 * (CL - 1 - i))) & 16'hF);
      m_entry.delete();
      m_shadow.delete();
   endfunction

   function automatic void decide();
      bit ok = 1;
      for (int i = 0; i < CL; i++) if (m_entry[i] != m_code[i]) ok = 0;
      if (ok) begin
         m_state = 2;
         m_fail  = 0;
      end else begin
         m_state    = 3;
         m_fail     = (m_fail < MF) ? m_fail + 1 : MF;
         m_deadline = cyc + EC;
      end
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         model_reset();
         model_ok = 1;
         pe = 0; pr = 0; pp = 0;
      end else if (model_ok) begin
         ee = enter_btn && !pe;
         er = relock_btn && !pr;
         ep = prog_btn && !pp;
         case (m_state)
            0, 1: begin
               if (ee) begin
                  if (m_state == 0) m_entry.delete();
                  m_entry.push_back(int'(in_digit));
                  if (m_entry.size() == CL) decide();
                  else begin
                     m_state    = 1;
                     m_deadline = cyc + ET;
                  end
               end else if (m_state == 1 && cyc == m_deadline) m_state = 0;
            end
            3: if (cyc == m_deadline) begin
                  if (m_fail == MF) begin
                     m_state    = 4;
                     m_deadline = cyc + LC;
                  end else m_state = 0;
               end
            4: if (cyc == m_deadline) begin
                  m_state = 0;
                  m_fail  = 0;
               end
            2: begin
               if (er) m_state = 0;
               else if (ep) begin
                  m_state = 5;
                  m_shadow.delete();
                  m_deadline = cyc + ET;
               end
            end
            5: begin
               if (er) m_state = 0;
               else if (ee) begin
                  m_shadow.push_back(int'(in_digit));
                  if (m_shadow.size() == CL) begin
                     for (int i = 0; i < CL; i++) m_code[i] = m_shadow[i];
                     m_state = 0;
                  end else m_deadline = cyc + ET;
               end else if (cyc == m_deadline) m_state = 0;
            end
            default: m_state = 0;
         endcase
         pe = enter_btn; pr = relock_btn; pp = prog_btn;
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("state_leds",   int'(state_leds),   m_state);
         chk("locked_led",   int'(locked_led),   int'(m_state inside {0, 1, 3, 4}));
         chk("unlocked_led", int'(unlocked_led), int'(m_state inside {2, 5}));
         chk("error_led",    int'(error_led),    int'(m_state == 3));
         chk("lockout_led",  int'(lockout_led),  int'(m_state == 4));
         chk("fail_count",   int'(fail_count),   m_fail);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic press(input int d, input int hold = 1);
      in_digit  = d[3:0];
      enter_btn = 1'b1;
      repeat (hold) @(negedge clk);
      enter_btn = 1'b0;
   endtask

   task automatic press4(input int a, input int b, input int c, input int d);
      press(a); tick(); press(b); tick(); press(c); tick(); press(d);
   endtask

   task automatic pulse_relock();
      relock_btn = 1'b1; tick(); relock_btn = 1'b0;
   endtask

   task automatic pulse_prog();
      prog_btn = 1'b1; tick(); prog_btn = 1'b0;
   endtask

   task automatic count_state(input int st, output int n);
      n = 0;
      while (int'(state_leds) == st && n < 500) begin
         n++;
         tick();
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_locked"},   int'(locked_led),   1);
      chk({tag, "_unlocked"}, int'(unlocked_led), 0);
      chk({tag, "_error"},    int'(error_led),    0);
      chk({tag, "_lockout"},  int'(lockout_led),  0);
      chk({tag, "_state"},    int'(state_leds),   0);
      chk({tag, "_fail"},     int'(fail_count),   0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int n, r, idx;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      chk_reset_outputs("rst");

      // Unlock and relock.
      tick(); press4(1, 2, 3, 4);
      chk("unlock_led", int'(unlocked_led), 1);
      chk("unlock_state", int'(state_leds), 2);
      chk("unlock_fail", int'(fail_count), 0);
      tick(); pulse_relock();
      chk("relock_state", int'(state_leds), 0);

      // Wrong first digit is not revealed early.
      tick(); press(9); tick(); press(2); tick(); press(3);
      chk("no_early_reject", int'(state_leds), 1);
      tick(); press(4);
      count_state(3, n);
      chk("err_len", n, EC);
      chk("err_fail", int'(fail_count), 1);
      chk("err_then_idle", int'(state_leds), 0);

      // Two more failures reach lockout; presses inside lockout are ignored.
      tick(); press4(9, 9, 9, 9); count_state(3, n);
      tick(); press4(5, 5, 5, 5); count_state(3, n);
      chk("enter_lockout", int'(lockout_led), 1);
      chk("lockout_fail", int'(fail_count), 3);
      n = 0;
      while (int'(state_leds) == 4 && n < 500) begin
         n++;
         in_digit  = 4'((n / 2) % 4 + 1);
         enter_btn = n[0];
         tick();
      end
      enter_btn = 1'b0;
      chk("lockout_len", n, LC);
      chk("after_lockout_state", int'(state_leds), 0);
      chk("after_lockout_fail", int'(fail_count), 0);

      // Reprogram to 5678, then an aborted reprogram keeps it.
      tick(); press4(1, 2, 3, 4);
      tick(); pulse_prog();
      chk("prog_state", int'(state_leds), 5);
      tick(); press4(5, 6, 7, 8);
      chk("prog_commit_idle", int'(state_leds), 0);
      tick(); press4(1, 2, 3, 4);
      chk("old_code_fails", int'(error_led), 1);
      count_state(3, n);
      tick(); press4(5, 6, 7, 8);
      chk("new_code_unlocks", int'(state_leds), 2);
      tick(); pulse_prog(); tick(); press(1); tick(); press(2); tick(); pulse_relock();
      chk("prog_abort_idle", int'(state_leds), 0);
      tick(); press4(5, 6, 7, 8);
      chk("abort_keeps_code", int'(state_leds), 2);
      tick(); pulse_relock();

      // Timeout does not count as a failure; held enter is one digit.
      tick(); press4(1, 1, 1, 1); count_state(3, n);
      tick(); press(5); tick(); press(6);
      count_state(1, n);
      chk("timeout_len", n, ET);
      chk("timeout_fail_kept", int'(fail_count), 1);
      tick(); press(5, 10); tick(); press(6); tick(); press(7); tick(); press(8);
      chk("held_one_digit", int'(state_leds), 2);
      tick(); pulse_relock();

      // Reset during lockout, then reset during programming.
      for (int k = 0; k < 3; k++) begin
         tick(); press4(0, 0, 0, 0); count_state(3, n);
      end
      repeat (5) tick();
      chk("pre_reset_lockout", int'(lockout_led), 1);
      reset = 1'b1; tick(); reset = 1'b0;
      chk_reset_outputs("rst_lockout");
      tick(); press4(1, 2, 3, 4);
      chk("default_code_back", int'(state_leds), 2);
      tick(); pulse_prog(); tick(); press(9); tick(); press(9);
      reset = 1'b1; tick(); reset = 1'b0;
      chk_reset_outputs("rst_prog");
      tick(); press4(1, 2, 3, 4);
      chk("default_after_prog_reset", int'(state_leds), 2);
      tick(); pulse_relock();

      // Random traffic, biased toward correct digits so every state is visited.
      for (int c = 0; c < 4000; c++) begin
         r = int'($urandom_range(0, 99));
         if (enter_btn) enter_btn = (r < 30);
         else if (r < 40) begin
            enter_btn = 1'b1;
            idx = (m_state == 1) ? m_entry.size() : 0;
            if (idx > CL - 1) idx = CL - 1;
            if ($urandom_range(0, 99) < 75 && m_state inside {0, 1}) in_digit = 4'(m_code[idx]);
            else in_digit = 4'($urandom_range(0, 15));
         end
         relock_btn = ($urandom_range(0, 99) < 3);
         prog_btn   = ($urandom_range(0, 99) < 6);
         reset      = ($urandom_range(0, 999) == 0);
         tick();
      end
      reset = 1'b0; enter_btn = 1'b0; relock_btn = 1'b0; prog_btn = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lock_core_param.md
# lock_core_param

Parametrised successor to the 4-bit digit-entry combination lock core. It accepts a CODE_LEN-digit code one digit per enter press, and counts consecutive failures into a timed lockout. It aborts stale entries on inactivity and lets the user reprogram the code while unlocked. It sits behind the pad-mapping top wrapper and drives the lock status LEDs directly.

## Interface
Parameters:
- DIGIT_W, 4: bits per digit.
- CODE_LEN, 4: digits per code, ≥1.
- DEFAULT_CODE, 16'h1234: reset code, CODE_LEN*DIGIT_W bits; first-entered digit is the most-significant digit.
- MAX_FAIL, 3: consecutive failures that trigger lockout, ≥1.
- ERR_CYCLES, 8: ERROR display duration, ≥1.
- LOCKOUT_CYCLES, 1024: LOCKOUT duration, ≥1.
- ENTRY_TIMEOUT, 4096: idle cycles in ENTRY/PROGRAM before abort, ≥1.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- in_digit  in  DIGIT_W  digit value, sampled on an enter event.
- enter_btn  in  1  level, already synchronised; its rising edge is the enter event.
- relock_btn  in  1  level, already synchronised; its rising edge is the relock event.
- prog_btn  in  1  level, already synchronised; its rising edge is the program event.
- locked_led  out  1  high in IDLE, ENTRY, ERROR and LOCKOUT.
- unlocked_led  out  1  high in UNLOCKED and PROGRAM.
- error_led  out  1  high in ERROR.
- lockout_led  out  1  high in LOCKOUT.
- state_leds  out  3  state encoding.
- fail_count  out  $clog2(MAX_FAIL+1)  consecutive failures so far.

## Operation
State encoding: IDLE=0, ENTRY=1, UNLOCKED=2, ERROR=3, LOCKOUT=4, PROGRAM=5.

- **Event detection:** each button has a 1-flop history. An event is `btn & ~btn_q`. Holding a button high produces exactly one event.
- **IDLE:** an enter event compares in_digit with code digit 0, sets the mismatch flag if they differ, sets digit index = 1 and moves to ENTRY. The digit index resets to 0 on the next attempt.
- **ENTRY:** each enter event compares in_digit against code[idx] and ORs any mismatch into the flag.
  - On the last digit (idx = CODE_LEN-1): if the accumulated flag is clear, go to UNLOCKED and set fail_count = 0. Otherwise go to ERROR and increment fail_count.
  - No early rejection: a wrong digit is never revealed before the last digit.
  - CODE_LEN=1: the first press already decides.
- **ERROR:** hold for ERR_CYCLES. Then go to LOCKOUT if fail_count == MAX_FAIL, else to IDLE.
- **LOCKOUT:** ignore every input for LOCKOUT_CYCLES, then go to IDLE with fail_count = 0.
- **UNLOCKED:** a relock event goes to IDLE; a program event goes to PROGRAM. If both arrive in the same cycle, relock wins.
- **PROGRAM:**
  - CODE_LEN enter events write in_digit, MSD first, into a shadow register.
  - When the last digit is written, commit the shadow to the code register and go to IDLE, i.e. locked.
  - A relock event aborts to IDLE with the code unchanged.
- **Timeout:** in ENTRY or PROGRAM, ENTRY_TIMEOUT cycles with no enter event abort to IDLE. The abort does not count as a failure; index, flag and shadow are cleared.
- **Ignored events:** enter events in ERROR/LOCKOUT are ignored. Relock/program events outside UNLOCKED/PROGRAM are ignored.
- **Reset:** state = IDLE, code = DEFAULT_CODE, fail_count = 0, all counters/index/flag = 0, button histories = 0.
  - Reset outputs: locked_led=1, unlocked_led=0, error_led=0, lockout_led=0, state_leds=0, fail_count=0.
  - Reset mid-PROGRAM discards the shadow and restores DEFAULT_CODE.

## Timing
- **Output timing:** all outputs are decoded from registered state with no combinational input-to-output path.
- **Event latency:** an event sampled at edge N causes its state change at edge N; the outputs reflect it after edge N.
- **Unlock latency:** a correct code unlocks at the edge of the final press, i.e. 1 cycle after the final enter_btn rises.
- **ERROR duration:** exactly ERR_CYCLES cycles, counted from the first ERROR cycle.
- **LOCKOUT duration:** exactly LOCKOUT_CYCLES cycles.
- **Timeout:** fires after exactly ENTRY_TIMEOUT cycles with no enter event; the timer restarts on every enter event.
- **Code update:** the committed code is effective from the first IDLE cycle after PROGRAM completes.
- **Counter widths:** each counter is $clog2(max+1) bits. fail_count saturates at MAX_FAIL and never wraps.

## Structure
- **Shared package lock_pkg:**
  - state enum (3-bit) with the encodings above;
  - LED/state_leds decode constants.
- **Sub-module lock_btn_edge:** edge detector, 1 flop plus AND, instantiated three times.
- **Core:** everything else is one FSM with one shared duration counter, used by ERROR, LOCKOUT and the timeout.

## Test plan
All scenarios use DIGIT_W=4, CODE_LEN=4, DEFAULT_CODE=16'h1234, MAX_FAIL=3, ERR_CYCLES=8, LOCKOUT_CYCLES=32, ENTRY_TIMEOUT=64.
- **Reset / unlock / relock:** reset, then press 1,2,3,4 → unlocked_led=1 and state_leds=2 one cycle after the 4th press, fail_count=0. Relock → state_leds=0 next cycle.
- **Wrong digit first:** press 9,2,3,4 → no state change before the 4th press. Then ERROR for exactly 8 cycles, fail_count=1, then IDLE.
- **Lockout:** three wrong codes → LOCKOUT (lockout_led=1) for 32 cycles. During lockout, enter presses with 1,2,3,4 are ignored. Then IDLE with fail_count=0.
- **Reprogram:** after unlock, press prog then 5,6,7,8 → IDLE. Code 1234 now fails; 5678 unlocks. A relock mid-PROGRAM keeps the old code.
- **Timeout and held button:** press 1,2 then idle 64 cycles → IDLE with fail_count unchanged. Holding enter_btn high for 10 cycles counts as exactly one digit.
- **Reset mid-operation:** reset asserted during LOCKOUT or mid-PROGRAM → all reset output values; code is back to 1234.
